seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, meaning the longest detectable pattern in bits (range 2..32).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the match-counter width in bits.
REQ-003 SHALL have parameter LEN_W, default $clog2(MAX_LEN+1), meaning the pat_len width; derived, never overridden.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port din, input, 1, serial data bit.
REQ-007 SHALL have port din_valid, input, 1, din is sampled only when this is high.
REQ-008 SHALL have port cfg_load, input, 1, single-cycle request to latch pattern/pat_len/overlap.
REQ-009 SHALL have port pattern, input, MAX_LEN, target sequence; bit pat_len-1 is the first bit received, bit 0 is the last.
REQ-010 SHALL have port pat_len, input, LEN_W, active pattern length.
REQ-011 SHALL have port overlap, input, 1, 1 = overlapping detection, 0 = non-overlapping.
REQ-012 SHALL have port dout, output, 1, registered single-cycle match pulse.
REQ-013 SHALL have port match_count, output, CNT_W, saturating count of matches since reset or last accepted cfg_load.
REQ-014 SHALL have port armed, output, 1, high when a valid configuration is held.
REQ-015 SHALL have port cfg_err, output, 1, single-cycle pulse on a rejected cfg_load.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (no configuration; din ignored) and ARMED (detecting).
REQ-017 SHALL accept cfg_load only when 1 <= pat_len <= MAX_LEN; acceptance latches pattern, pat_len and overlap into internal registers, clears history, fill counter and match_count, and moves to ARMED from either state.
REQ-018 SHALL on a rejected cfg_load pulse cfg_err for one cycle and leave state, configuration, history and match_count unchanged.
REQ-019 SHALL give cfg_load priority over din_valid in the same cycle; that din sample is discarded.
REQ-020 SHALL in ARMED with din_valid high shift din into a MAX_LEN-bit history register (new bit at LSB) and increment a fill counter that saturates at MAX_LEN.
REQ-021 SHALL declare a match when fill (including the current bit) >= latched length and the lowest length bits of the updated history equal the latched pattern bits [length-1:0].
REQ-022 SHALL drive dout high for exactly the one cycle following the clock edge that sampled the completing bit; dout is low in every other cycle, including din_valid-low cycles.
REQ-023 SHALL in overlap=1 mode keep history and fill after a match, so a pattern suffix may start the next match.
REQ-024 SHALL in overlap=0 mode reset fill to 0 on the edge of a match, so no bit participates in two matches.
REQ-025 SHALL increment match_count by 1 per match and hold it at all-ones on saturation without wrapping.
REQ-026 SHALL treat din_valid-low cycles as stalls: history, fill and match evaluation are frozen.
REQ-027 SHALL produce no match, count or history change in IDLE.

Reset
REQ-028 SHALL on rst high at a clock edge enter IDLE and force dout=0, cfg_err=0, armed=0, match_count=0, history=0, fill=0, latched config=0, overriding cfg_load and din_valid.
REQ-029 SHALL after rst mid-sequence require a new accepted cfg_load before any detection.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE, ARMED) and the MAX_LEN range limits in shared package seq_det_pkg.
REQ-031 SHALL instantiate one sub-module, seq_det_history, holding the history shift register and saturating fill counter; FSM, compare and counting stay in the top module.

Verification
REQ-032 SHALL cover: cfg pattern=4'b1001, pat_len=4, overlap=0; din 1,0,0,1,0,0,1 continuous -> one dout pulse, after bit 4; match_count=1.
REQ-033 SHALL cover: same stream with overlap=1 -> dout after bits 4 and 7; match_count=2.
REQ-034 SHALL cover: pat_len=0 and pat_len=MAX_LEN+1 cfg_load -> cfg_err pulse, armed and match_count unchanged.
REQ-035 SHALL cover: 1001 with din_valid low for 3 cycles between each bit -> single dout pulse one cycle after the edge sampling the final 1.
REQ-036 SHALL cover: CNT_W=2, pattern 1'b1, pat_len=1, overlap=1, six 1s -> match_count 1,2,3,3,3,3; dout high six times.
REQ-037 SHALL cover: rst after bits 1,0,0, then cfg_load and bit 1 -> no dout; armed=0 until cfg_load accepted.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants for the parameterised serial sequence detector:
// FSM state encoding and the legal range of MAX_LEN.
package seq_det_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    localparam int MAX_LEN_MIN = 2;
    localparam int MAX_LEN_MAX = 32;

endpackage

// File: rtl/seq_det_history.sv
// History shift register (newest bit at LSB) plus a fill counter that
// saturates at MAX_LEN. The post-shift values are exposed for the compare.
module seq_det_history
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift,
    input  logic               fill_clr,
    input  logic               din,
    output logic [MAX_LEN-1:0] hist_nxt,
    output logic [LEN_W-1:0]   fill_nxt
);

    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    assign hist_nxt = {hist[MAX_LEN-2:0], din};
    assign fill_nxt = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;

    // fill_clr lets a non-overlapping match consume every bit it used.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= hist_nxt;
            fill <= fill_clr ? '0 : fill_nxt;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with overlap control and a
// saturating match counter. Configuration is latched on an accepted cfg_load.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    output logic               dout,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed,
    output logic               cfg_err
);

    logic [0:0]         state;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;

    logic               cfg_ok;
    logic               cfg_acc;
    logic               shift;
    logic               match;
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [LEN_W-1:0]   fill_nxt;

    assign cfg_ok  = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
    assign cfg_acc = cfg_load && cfg_ok;
    // A cfg_load cycle always discards the din sample, accepted or not.
    assign shift   = (state == ST_ARMED) && din_valid && !cfg_load;
    assign armed   = (state == ST_ARMED);

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign match = shift && (fill_nxt >= len_q) && (((hist_nxt ^ pat_q) & mask) == '0);

    seq_det_history #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_history (
        .clk      (clk),
        .rst      (rst),
        .clr      (cfg_acc),
        .shift    (shift),
        .fill_clr (match && !ovl_q),
        .din      (din),
        .hist_nxt (hist_nxt),
        .fill_nxt (fill_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            dout        <= 1'b0;
            cfg_err     <= 1'b0;
            match_count <= '0;
        end else begin
            dout    <= match;
            cfg_err <= cfg_load && !cfg_ok;
            if (cfg_acc) begin
                state       <= ST_ARMED;
                pat_q       <= pattern;
                len_q       <= pat_len;
                ovl_q       <= overlap;
                match_count <= '0;
            end else if (match && (match_count != '1)) begin
                match_count <= match_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios then random traffic, all
// checked each cycle against a bit-queue reference model.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               din = 1'b0;
    logic               din_valid = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] pattern = '0;
    logic [LEN_W-1:0]   pat_len = '0;
    logic               overlap = 1'b0;

    logic               dout_a, armed_a, err_a;
    logic [7:0]         cnt_a;
    logic               dout_b, armed_b, err_b;
    logic [1:0]         cnt_b;

    // clock / reset
    always #5 clk = ~clk;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len), .overlap(overlap),
        .dout(dout_a), .match_count(cnt_a), .armed(armed_a), .cfg_err(err_a)
    );

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len), .overlap(overlap),
        .dout(dout_b), .match_count(cnt_b), .armed(armed_b), .cfg_err(err_b)
    );

    // reference model state
    logic               m_armed = 1'b0;
    logic [MAX_LEN-1:0] m_pat = '0;
    int                 m_len = 0;
    logic               m_ovl = 1'b0;
    logic               m_bits[$];
    int                 m_cnt8 = 0;
    int                 m_cnt2 = 0;
    logic               m_dout = 1'b0;
    logic               m_err = 1'b0;
    int                 n_dout_b = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Model from the rules: bits since the last clear, newest at the back;
    // a match is the last len bits equal to pattern, first-received bit at len-1.
    task automatic model_step();
        logic hit;
        m_dout = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            m_armed = 1'b0; m_pat = '0; m_len = 0; m_ovl = 1'b0;
            m_bits.delete(); m_cnt8 = 0; m_cnt2 = 0;
        end else if (cfg_load) begin
            if (int'(pat_len) >= 1 && int'(pat_len) <= MAX_LEN) begin
                m_armed = 1'b1; m_pat = pattern; m_len = int'(pat_len); m_ovl = overlap;
                m_bits.delete(); m_cnt8 = 0; m_cnt2 = 0;
            end else begin
                m_err = 1'b1;
            end
        end else if (m_armed && din_valid) begin
            m_bits.push_back(din);
            if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            hit = (m_bits.size() >= m_len);
            for (int k = 0; k < m_len && hit; k++)
                if (m_bits[m_bits.size() - 1 - k] !== m_pat[k]) hit = 1'b0;
            if (hit) begin
                m_dout = 1'b1;
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
                if (!m_ovl) m_bits.delete();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("dout", 32'(dout_a), 32'(m_dout));
        check("count", 32'(cnt_a), 32'(m_cnt8));
        check("armed", 32'(armed_a), 32'(m_armed));
        check("cfg_err", 32'(err_a), 32'(m_err));
        check("dout_w2", 32'(dout_b), 32'(m_dout));
        check("count_w2", 32'(cnt_b), 32'(m_cnt2));
        if (dout_b) n_dout_b++;
    endtask

    // driver tasks
    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic do_cfg(input logic [MAX_LEN-1:0] p, input int l, input logic o);
        cfg_load = 1'b1; pattern = p; pat_len = LEN_W'(l); overlap = o;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        din = b; din_valid = 1'b1; tick(); din_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            din = $urandom_range(0, 1); tick();
        end
    endtask

    task automatic send_stream(input logic [15:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i], gap);
    endtask

    initial begin
        logic [15:0] s;
        // reset state
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_armed", 32'(armed_a), 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);

        // 1001 non-overlapping on 1001001: one match
        do_cfg(8'b1001, 4, 1'b0);
        s = 16'b1001001;
        send_stream(s, 7, 0);
        check("nonovl_total", 32'(cnt_a), 32'd1);

        // same stream overlapping: two matches
        do_cfg(8'b1001, 4, 1'b1);
        send_stream(s, 7, 0);
        check("ovl_total", 32'(cnt_a), 32'd2);

        // rejected lengths leave everything unchanged
        do_cfg(8'hff, 0, 1'b0);
        check("rej0_count", 32'(cnt_a), 32'd2);
        do_cfg(8'hff, MAX_LEN + 1, 1'b0);
        check("rej9_armed", 32'(armed_a), 32'd1);

        // stalls between bits
        do_cfg(8'b1001, 4, 1'b0);
        s = 16'b1001;
        send_stream(s, 4, 3);
        check("stall_total", 32'(cnt_a), 32'd1);

        // CNT_W=2 saturation with a single-bit pattern
        do_cfg(8'b1, 1, 1'b1);
        n_dout_b = 0;
        send_stream(16'h3f, 6, 0);
        check("sat_count_w2", 32'(cnt_b), 32'd3);
        check("sat_pulses", 32'(n_dout_b), 32'd6);

        // reset mid-sequence requires a new configuration
        do_cfg(8'b1001, 4, 1'b0);
        send_stream(16'b100, 3, 0);
        do_reset();
        send_bit(1'b1, 1);
        check("post_rst_armed", 32'(armed_a), 32'd0);
        do_cfg(8'b1001, 4, 1'b0);
        send_bit(1'b1, 1);
        check("post_rst_count", 32'(cnt_a), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            cfg_load  = ($urandom_range(0, 59) == 0);
            pattern   = MAX_LEN'($urandom());
            pat_len   = LEN_W'($urandom_range(0, MAX_LEN + 1));
            if ($urandom_range(0, 2) != 0 && pat_len > 3) pat_len = LEN_W'($urandom_range(1, 3));
            overlap   = $urandom_range(0, 1);
            din       = $urandom_range(0, 1);
            din_valid = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0; cfg_load = 1'b0; din_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
